// File: rtl/xor_nand_pkg.sv
// ---------------------------------------------------------------------------
// xor_nand_pkg
// Shared constants for the NAND-only XOR block.
//   XOR_NAND_WIDTH_DEFAULT : default number of XOR lanes.
//   *_RST                  : reset values for the registered outputs.
// ---------------------------------------------------------------------------
package xor_nand_pkg;

    localparam int   XOR_NAND_WIDTH_DEFAULT = 1;

    localparam logic Z_RST_BIT     = 1'b0;
    localparam logic PARITY_RST    = 1'b0;
    localparam logic OUT_VALID_RST = 1'b0;
    localparam logic ERR_RST       = 1'b0;

endpackage : xor_nand_pkg

// File: rtl/nand2_cell.sv
// ---------------------------------------------------------------------------
// nand2_cell
// Two-input NAND primitive; the only gate the XOR network is built from.
// Ports:
//   a, b : inputs
//   y    : ~(a & b)
// ---------------------------------------------------------------------------
module nand2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule : nand2_cell

// File: rtl/xor_using_nand.sv
// ---------------------------------------------------------------------------
// xor_using_nand
// Bitwise A XOR B built purely from nand2_cell instances (four per lane),
// plus an XOR-reduction parity formed by a linear chain of the same
// four-NAND cells. Z, parity and out_valid are registered (1-cycle latency).
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (overrides in_valid)
//   in_valid  : A/B sampled on this edge when high
//   A, B      : WIDTH-bit operands
//   Z         : registered A ^ B
//   parity    : registered XOR-reduction of Z
//   out_valid : one-cycle pulse when Z/parity update
//   err       : (only with XOR_NAND_SELFCHECK_EN) sticky flag, set when the
//               NAND network disagrees with a behavioural reference
//
// Optional feature macro: XOR_NAND_SELFCHECK_EN
// ---------------------------------------------------------------------------
module xor_using_nand
    import xor_nand_pkg::*;
#(
    parameter int WIDTH = XOR_NAND_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Z,
    output logic             parity,
`ifdef XOR_NAND_SELFCHECK_EN
    output logic             out_valid,
    output logic             err
`else
    output logic             out_valid
`endif
);

    logic [WIDTH-1:0] xor_s;
    logic [WIDTH-1:0] par_s;

    logic [WIDTH-1:0] z_d,         z_q;
    logic             parity_d,    parity_q;
    logic             out_valid_d, out_valid_q;

    // Per-lane four-NAND XOR: n1=~(a&b), n2=~(a&n1), n3=~(b&n1), z=~(n2&n3)
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic n1_s, n2_s, n3_s;
        nand2_cell u_n1 (.a(A[i]), .b(B[i]), .y(n1_s));
        nand2_cell u_n2 (.a(A[i]), .b(n1_s), .y(n2_s));
        nand2_cell u_n3 (.a(B[i]), .b(n1_s), .y(n3_s));
        nand2_cell u_n4 (.a(n2_s), .b(n3_s), .y(xor_s[i]));
    end

    // Parity chain seed: with a single lane the parity is just that lane.
    assign par_s[0] = xor_s[0];

    // Linear parity chain: stage i folds lane i into the running parity.
    for (genvar i = 1; i < WIDTH; i++) begin : g_par
        logic n1_s, n2_s, n3_s;
        nand2_cell u_n1 (.a(par_s[i-1]), .b(xor_s[i]), .y(n1_s));
        nand2_cell u_n2 (.a(par_s[i-1]), .b(n1_s),     .y(n2_s));
        nand2_cell u_n3 (.a(xor_s[i]),   .b(n1_s),     .y(n3_s));
        nand2_cell u_n4 (.a(n2_s),       .b(n3_s),     .y(par_s[i]));
    end

    // Next-state: capture on valid, otherwise hold the last result.
    always_comb begin
        z_d         = z_q;
        parity_d    = parity_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            z_d         = xor_s;
            parity_d    = par_s[WIDTH-1];
            out_valid_d = 1'b1;
        end else begin
            z_d         = z_q;
            parity_d    = parity_q;
            out_valid_d = 1'b0;
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q         <= {WIDTH{Z_RST_BIT}};
            parity_q    <= PARITY_RST;
            out_valid_q <= OUT_VALID_RST;
        end else begin
            z_q         <= z_d;
            parity_q    <= parity_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Z         = z_q;
    assign parity    = parity_q;
    assign out_valid = out_valid_q;

`ifdef XOR_NAND_SELFCHECK_EN
    logic err_d, err_q;

    // Sticky error: any valid-cycle disagreement with the reference latches.
    always_comb begin
        err_d = err_q;
        if (in_valid && (xor_s != (A ^ B))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= ERR_RST;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule : xor_using_nand

// File: tb/tb_xor_using_nand.sv
module tb_xor_using_nand;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] z8;
    logic       p8, ov8;
    logic [0:0] z1;
    logic       p1, ov1;
`ifdef XOR_NAND_SELFCHECK_EN
    logic       err8, err1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    xor_using_nand #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A), .B(B), .Z(z8), .parity(p8),
`ifdef XOR_NAND_SELFCHECK_EN
        .out_valid(ov8), .err(err8)
`else
        .out_valid(ov8)
`endif
    );

    xor_using_nand #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A[0:0]), .B(B[0:0]), .Z(z1), .parity(p1),
`ifdef XOR_NAND_SELFCHECK_EN
        .out_valid(ov1), .err(err1)
`else
        .out_valid(ov1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] z;
        logic       p;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic       p;
    } vec_t;

    exp_t       sb_q[$];
    logic [7:0] hold_z;
    logic       hold_p;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle, let the edge happen, then check all outputs.
    task automatic cycle(input logic rst, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input exp_t e);
        exp_t cur;
        logic exp_ov;
        rst_n    = rst;
        in_valid = v;
        A        = a;
        B        = b;
        if (rst && v) sb_q.push_back(e);
        @(posedge clk);
        #1;
        exp_ov = rst && v;
        if (!rst) begin
            sb_q.delete();
            hold_z = 8'h00;
            hold_p = 1'b0;
        end
        if (exp_ov) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: empty queue, required one entry");
            end else begin
                cur    = sb_q.pop_front();
                hold_z = cur.z;
                hold_p = cur.p;
            end
        end
        chk("out_valid8", {7'd0, ov8}, {7'd0, exp_ov});
        chk("out_valid1", {7'd0, ov1}, {7'd0, exp_ov});
        chk("z8",         z8,          hold_z);
        chk("parity8",    {7'd0, p8},  {7'd0, hold_p});
        chk("z1",         {7'd0, z1},  {7'd0, hold_z[0]});
        chk("parity1",    {7'd0, p1},  {7'd0, hold_z[0]});
`ifdef XOR_NAND_SELFCHECK_EN
        chk("err8", {7'd0, err8}, 8'h00);
        chk("err1", {7'd0, err1}, 8'h00);
`endif
    endtask

    vec_t vecs[10];
    exp_t e;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        hold_z   = 8'h00;
        hold_p   = 1'b0;

        // Expected values worked out by hand from the XOR truth table.
        vecs[0] = '{a: 8'h00, b: 8'h00, z: 8'h00, p: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, z: 8'h01, p: 1'b1};
        vecs[2] = '{a: 8'h01, b: 8'h00, z: 8'h01, p: 1'b1};
        vecs[3] = '{a: 8'h01, b: 8'h01, z: 8'h00, p: 1'b0};
        vecs[4] = '{a: 8'hA5, b: 8'h0F, z: 8'hAA, p: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'h01, z: 8'hFE, p: 1'b1};
        vecs[6] = '{a: 8'h3C, b: 8'hC3, z: 8'hFF, p: 1'b0};
        vecs[7] = '{a: 8'h80, b: 8'h00, z: 8'h80, p: 1'b1};
        vecs[8] = '{a: 8'h12, b: 8'h34, z: 8'h26, p: 1'b1};
        vecs[9] = '{a: 8'hFF, b: 8'hFF, z: 8'h00, p: 1'b0};

        // Reset held two cycles with valid data present: outputs stay zero.
        e = '{z: 8'h01, p: 1'b1};
        cycle(1'b0, 1'b1, 8'h01, 8'h00, e);
        cycle(1'b0, 1'b1, 8'h01, 8'h00, e);

        // Back-to-back table vectors, one result per cycle.
        for (int i = 0; i < 10; i++) begin
            e = '{z: vecs[i].z, p: vecs[i].p};
            cycle(1'b1, 1'b1, vecs[i].a, vecs[i].b, e);
        end

        // Hold: load Z=1, then three idle cycles with changed operands.
        e = '{z: 8'h01, p: 1'b1};
        cycle(1'b1, 1'b1, 8'h01, 8'h00, e);
        for (int i = 0; i < 3; i++) begin
            e = '{z: 8'h00, p: 1'b0};
            cycle(1'b1, 1'b0, 8'h01, 8'h01, e);
        end

        // Reset mid-stream discards the result, then a fresh one follows.
        e = '{z: 8'h01, p: 1'b1};
        cycle(1'b1, 1'b1, 8'h01, 8'h00, e);
        cycle(1'b0, 1'b1, 8'h01, 8'h00, e);
        e = '{z: 8'h01, p: 1'b1};
        cycle(1'b1, 1'b1, 8'h00, 8'h01, e);

        // Exhaustive 2-bit sweep on the low lanes.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] av, bv, zv;
                av = 8'(a);
                bv = 8'(b);
                zv = av ^ bv;
                e  = '{z: zv, p: ^zv};
                cycle(1'b1, 1'b1, av, bv, e);
            end
        end
        cycle(1'b1, 1'b0, 8'h00, 8'h00, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_xor_using_nand
